// File: rtl/cdb_arb.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arb
// Brief   : 2-deep result FIFO per requester feeding a round-robin CDB arbiter
// Rev     : 1.0  initial release
// ============================================================================
module cdb_arb #(
  parameter int NUM_REQ = 4,
  parameter int NUM_CDB = 2,
  parameter int ROBID_W = 6,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [NUM_REQ-1:0]         req_v_i,
  input  logic [NUM_REQ*ROBID_W-1:0] req_robid_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]         req_rdy_o,
  output logic [NUM_CDB-1:0]         cdb_v_o,
  output logic [NUM_CDB*ROBID_W-1:0] cdb_robid_o,
  output logic [NUM_CDB*DATA_W-1:0]  cdb_data_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [1:0]         count_q     [NUM_REQ];
  logic               head_q      [NUM_REQ];
  logic [ROBID_W-1:0] mem_robid_q [NUM_REQ][2];
  logic [DATA_W-1:0]  mem_data_q  [NUM_REQ][2];
  logic [ROBID_W-1:0] head_robid  [NUM_REQ];
  logic [DATA_W-1:0]  head_data   [NUM_REQ];
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] grant;
  int                 pos  [NUM_REQ];
  int                 rank [NUM_REQ];

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_CDB-1:0] cdb_v_q, cdb_v_d;
  logic [ROBID_W-1:0] cdb_robid_q [NUM_CDB];
  logic [ROBID_W-1:0] cdb_robid_d [NUM_CDB];
  logic [DATA_W-1:0]  cdb_data_q  [NUM_CDB];
  logic [DATA_W-1:0]  cdb_data_d  [NUM_CDB];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
    assign req_rdy_o[r]  = (count_q[r] != 2'd2);
    assign push[r]       = req_v_i[r] & req_rdy_o[r];
    assign head_robid[r] = mem_robid_q[r][head_q[r]];
    assign head_data[r]  = mem_data_q[r][head_q[r]];
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REQ; r++) begin
      if (rst || flush_i) begin
        count_q[r] <= 2'd0;
        head_q[r]  <= 1'b0;
      end else begin
        count_q[r] <= count_q[r] + 2'(push[r]) - 2'(grant[r]);
        if (grant[r]) head_q[r] <= ~head_q[r];
      end
    end
  end

  // Tail slot is head + count (mod 2); a push into a full FIFO cannot happen.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REQ; r++) begin
      if (push[r]) begin
        mem_robid_q[r][head_q[r] ^ count_q[r][0]] <= req_robid_i[r*ROBID_W +: ROBID_W];
        mem_data_q[r][head_q[r] ^ count_q[r][0]]  <= req_data_i[r*DATA_W +: DATA_W];
      end
    end
  end

  // pos = distance from rr_ptr in scan order; rank = occupied heads ahead of it.
  always_comb begin
    int best;
    grant    = '0;
    rr_ptr_d = rr_ptr_q;
    best     = -1;
    for (int r = 0; r < NUM_REQ; r++) begin
      pos[r] = (r >= int'(rr_ptr_q)) ? (r - int'(rr_ptr_q)) : (r + NUM_REQ - int'(rr_ptr_q));
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      rank[r] = 0;
      for (int q = 0; q < NUM_REQ; q++) begin
        if (count_q[q] != 2'd0 && pos[q] < pos[r]) rank[r] = rank[r] + 1;
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (count_q[r] != 2'd0 && rank[r] < NUM_CDB) begin
        grant[r] = 1'b1;
        if (pos[r] > best) begin
          best     = pos[r];
          rr_ptr_d = (r == NUM_REQ - 1) ? '0 : PTR_W'(r + 1);
        end
      end
    end
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb_v_d[k]     = 1'b0;
      cdb_robid_d[k] = '0;
      cdb_data_d[k]  = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (grant[r] && rank[r] == k) begin
          cdb_v_d[k]     = 1'b1;
          cdb_robid_d[k] = head_robid[r];
          cdb_data_d[k]  = head_data[r];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      cdb_v_q  <= '0;
    end else if (flush_i) begin
      cdb_v_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_v_q  <= cdb_v_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb_robid_q[k] <= cdb_robid_d[k];
      cdb_data_q[k]  <= cdb_data_d[k];
    end
  end

  assign cdb_v_o = cdb_v_q;
  for (genvar k = 0; k < NUM_CDB; k++) begin : g_lane
    assign cdb_robid_o[k*ROBID_W +: ROBID_W] = cdb_robid_q[k];
    assign cdb_data_o[k*DATA_W +: DATA_W]    = cdb_data_q[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdb_arb
// Brief   : directed stimulus for cdb_arb checked against a queue-based model
// Rev     : 1.0  initial release
// ============================================================================
module tb_cdb_arb;

  localparam int N  = 4;
  localparam int C  = 2;
  localparam int IW = 6;
  localparam int DW = 32;

  logic            clk   = 1'b0;
  logic            rst   = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    req_v = '0;
  logic [IW-1:0]   rid  [N];
  logic [DW-1:0]   rdat [N];
  logic [N*IW-1:0] req_robid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_rdy;
  logic [C-1:0]    cdb_v;
  logic [C*IW-1:0] cdb_robid;
  logic [C*DW-1:0] cdb_data;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < N; r++) begin
      req_robid[r*IW +: IW] = rid[r];
      req_data[r*DW +: DW]  = rdat[r];
    end
  end

  cdb_arb #(.NUM_REQ(N), .NUM_CDB(C), .ROBID_W(IW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .req_v_i     (req_v),
    .req_robid_i (req_robid),
    .req_data_i  (req_data),
    .req_rdy_o   (req_rdy),
    .cdb_v_o     (cdb_v),
    .cdb_robid_o (cdb_robid),
    .cdb_data_o  (cdb_data)
  );

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dfn(input int r, input int id);
    return 32'hC0DE_0000 | DW'(r << 12) | DW'(id);
  endfunction

  task automatic set_req(input int r, input int id);
    rid[r]  = IW'(id);
    rdat[r] = dfn(r, id);
  endtask

  // ---------------- behavioural model: per-requester queues ----------------
  typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] d; } ent_t;
  ent_t         mq [N][$];
  int           mptr = 0;
  logic [C-1:0] ev   = '0;
  ent_t         el [C];

  always @(posedge clk) begin
    int   ng, last, r;
    bit   pop [N];
    bit   acc [N];
    ent_t e;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      mptr = 0;
      ev   = '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      ev = '0;
    end else begin
      ng   = 0;
      last = 0;
      ev   = '0;
      for (int i = 0; i < N; i++) begin
        pop[i] = 1'b0;
        acc[i] = req_v[i] && (mq[i].size() < 2);
      end
      for (int i = 0; i < N; i++) begin
        r = (mptr + i) % N;
        if (mq[r].size() > 0 && ng < C) begin
          el[ng] = mq[r][0];
          ev[ng] = 1'b1;
          pop[r] = 1'b1;
          last   = r;
          ng++;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (pop[i]) void'(mq[i].pop_front());
        if (acc[i]) begin
          e.id = rid[i];
          e.d  = rdat[i];
          mq[i].push_back(e);
        end
      end
      if (ng > 0) mptr = (last + 1) % N;
    end
  end

  // ---------------- per-cycle compare and CDB trace ----------------
  int           cdb_log [$];
  logic [C-1:0] q_v   [$];
  int           q_id0 [$];
  int           q_id1 [$];
  int           q_ptr [$];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int r = 0; r < N; r++)
        check($sformatf("rdy[%0d]", r), req_rdy[r], (mq[r].size() < 2));
      for (int k = 0; k < C; k++) begin
        check($sformatf("cdb_v[%0d]", k), cdb_v[k], ev[k]);
        if (ev[k]) begin
          check($sformatf("cdb_robid[%0d]", k), cdb_robid[k*IW +: IW], el[k].id);
          check($sformatf("cdb_data[%0d]", k), cdb_data[k*DW +: DW], el[k].d);
        end
        if (cdb_v[k] === 1'b1) cdb_log.push_back(int'(cdb_robid[k*IW +: IW]));
      end
      q_v.push_back(cdb_v);
      q_id0.push_back(int'(cdb_robid[IW-1:0]));
      q_id1.push_back(int'(cdb_robid[2*IW-1:IW]));
      q_ptr.push_back(mptr);
    end
  end

  // Hold the masked requesters valid; each one's robid advances on acceptance.
  task automatic stream(input int ncyc, input logic [N-1:0] mask);
    int           n [N];
    logic [N-1:0] acc;
    for (int r = 0; r < N; r++) n[r] = 0;
    for (int c = 0; c < ncyc; c++) begin
      for (int r = 0; r < N; r++) set_req(r, (4 * n[r] + r) % 64);
      req_v = mask;
      acc   = mask & req_rdy;
      @(negedge clk);
      for (int r = 0; r < N; r++) if (acc[r]) n[r]++;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_v = '0;
    @(negedge clk);
    rst   = 1'b0;
  endtask

  initial begin
    int           mark, idx, first, cnt;
    logic [N-1:0] a2;
    logic         rdy2_hist [4];
    int           seq [$];

    for (int r = 0; r < N; r++) set_req(r, 0);
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_rdy", req_rdy, 4'hF);
    check("reset_cdb_v", cdb_v, 2'b00);

    // Single result: visible exactly two cycles after being driven
    rst = 1'b0;
    set_req(0, 5);
    req_v = 4'b0001;
    @(negedge clk);
    req_v = '0;
    check("single_early_v", cdb_v, 2'b00);
    @(negedge clk);
    check("single_v", cdb_v, 2'b01);
    check("single_robid", cdb_robid[IW-1:0], 6'd5);
    check("single_data", cdb_data[DW-1:0], 32'hC0DE_0005);
    @(negedge clk);
    check("single_after_v", cdb_v, 2'b00);

    // All four push at once from rr_ptr = 0
    do_reset();
    for (int r = 0; r < N; r++) set_req(r, r + 1);
    req_v = 4'hF;
    @(negedge clk);
    req_v = '0;
    check("all4_c1_v", cdb_v, 2'b00);
    @(negedge clk);
    check("all4_c2_v", cdb_v, 2'b11);
    check("all4_c2_l0", cdb_robid[IW-1:0], 6'd1);
    check("all4_c2_l1", cdb_robid[2*IW-1:IW], 6'd2);
    @(negedge clk);
    check("all4_c3_v", cdb_v, 2'b11);
    check("all4_c3_l0", cdb_robid[IW-1:0], 6'd3);
    check("all4_c3_l1", cdb_robid[2*IW-1:IW], 6'd4);
    @(negedge clk);
    check("all4_c4_v", cdb_v, 2'b00);
    check("all4_model_ptr", mptr, 0);

    // Backpressure on requester 2 while 0 and 1 stay busy
    do_reset();
    mark = cdb_log.size();
    idx  = 0;
    set_req(0, 10);
    set_req(1, 11);
    for (int c = 0; c < 12; c++) begin
      req_v[0] = 1'b1;
      req_v[1] = 1'b1;
      if (idx < 3) begin
        set_req(2, 7 + idx);
        req_v[2] = 1'b1;
      end else begin
        req_v[2] = 1'b0;
      end
      if (c < 4) rdy2_hist[c] = req_rdy[2];
      a2 = req_v & req_rdy;
      @(negedge clk);
      if (a2[2]) idx++;
    end
    req_v = '0;
    repeat (6) @(negedge clk);
    check("bp_rdy2_c0", rdy2_hist[0], 1'b1);
    check("bp_rdy2_c1", rdy2_hist[1], 1'b1);
    check("bp_rdy2_full", rdy2_hist[2], 1'b0);
    check("bp_rdy2_after_pop", rdy2_hist[3], 1'b1);
    seq.delete();
    for (int i = mark; i < cdb_log.size(); i++)
      if (cdb_log[i] >= 7 && cdb_log[i] <= 9) seq.push_back(cdb_log[i]);
    check("bp_count", seq.size(), 3);
    if (seq.size() == 3) begin
      check("bp_order0", seq[0], 7);
      check("bp_order1", seq[1], 8);
      check("bp_order2", seq[2], 9);
    end

    // Fairness: alternating lane pairs {0,1},{2,3} with rr_ptr 2,0,2,0 after each
    do_reset();
    mark = q_v.size();
    stream(20, 4'hF);
    req_v = '0;
    repeat (4) @(negedge clk);
    first = -1;
    for (int i = mark; i < q_v.size(); i++)
      if (first < 0 && q_v[i] == 2'b11) first = i;
    check("fair_found", (first >= 0) && (first + 8 <= q_v.size()), 1'b1);
    if (first >= 0 && first + 8 <= q_v.size()) begin
      for (int j = 0; j < 8; j++) begin
        check($sformatf("fair_v[%0d]", j), q_v[first + j], 2'b11);
        check($sformatf("fair_l0[%0d]", j), q_id0[first + j] % 4, (j % 2 == 0) ? 0 : 2);
        check($sformatf("fair_l1[%0d]", j), q_id1[first + j] % 4, (j % 2 == 0) ? 1 : 3);
        check($sformatf("fair_ptr[%0d]", j), q_ptr[first + j], (j % 2 == 0) ? 2 : 0);
      end
    end

    // Flush with buffered entries and a simultaneous push; rr_ptr held at 2
    do_reset();
    stream(2, 4'hF);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    req_v = '0;
    check("flush_v", cdb_v, 2'b00);
    check("flush_rdy", req_rdy, 4'hF);
    check("flush_model_ptr", mptr, 2);
    mark = cdb_log.size();
    repeat (5) @(negedge clk);
    check("flush_no_leak", cdb_log.size(), mark);
    for (int r = 0; r < N; r++) set_req(r, r + 1);
    req_v = 4'hF;
    @(negedge clk);
    req_v = '0;
    @(negedge clk);
    check("flush_ptr_l0", cdb_robid[IW-1:0], 6'd3);
    check("flush_ptr_l1", cdb_robid[2*IW-1:IW], 6'd4);
    repeat (3) @(negedge clk);

    // Reset mid-stream: buffered results lost, scan restarts at requester 0
    stream(2, 4'hF);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    req_v = '0;
    check("rst_mid_v", cdb_v, 2'b00);
    check("rst_mid_rdy", req_rdy, 4'hF);
    mark = cdb_log.size();
    for (int r = 0; r < N; r++) set_req(r, r + 1);
    req_v = 4'hF;
    @(negedge clk);
    req_v = '0;
    repeat (4) @(negedge clk);
    cnt = cdb_log.size() - mark;
    check("rst_mid_count", cnt, 4);
    if (cnt == 4)
      for (int i = 0; i < 4; i++)
        check($sformatf("rst_mid_order[%0d]", i), cdb_log[mark + i], i + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
